// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar blocks.
package stream_xbar_pkg;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_e;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Round-robin first-set-bit picker: searches req from ptr upward, then wraps to 0.
module rr_prio_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx
);

   logic [N-1:0] mask;
   logic [N-1:0] masked;
   logic [N-1:0] src;
   logic         found;

   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < N; i++) begin
         mask[i] = (IW'(i) >= ptr);
      end
      masked = req & mask;
      // Masked bits win; fall back to the unmasked search when nothing sits at or above ptr.
      src    = (|masked) ? masked : req;

      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (src[i] && !found) begin
            onehot[i] = 1'b1;
            idx       = IW'(i);
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_rr_arb.sv
// Per-output-port stream arbiter: round-robin grant, locked for a whole packet.
module stream_rr_arb
   import stream_xbar_pkg::*;
#(
   parameter  int unsigned NUM_REQUEST = 4,
   parameter  int unsigned DATA_WIDTH  = 32,
   localparam int unsigned IW          = idx_w(NUM_REQUEST)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NUM_REQUEST-1:0]            s_valid_i,
   input  logic [NUM_REQUEST*DATA_WIDTH-1:0] s_data_i,
   input  logic [NUM_REQUEST-1:0]            s_last_i,
   output logic [NUM_REQUEST-1:0]            s_ready_o,
   output logic                              m_valid_o,
   output logic [DATA_WIDTH-1:0]             m_data_o,
   output logic                              m_last_o,
   input  logic                              m_ready_i,
   output logic [NUM_REQUEST-1:0]            grant_o,
   output logic [IW-1:0]                     grant_idx_o,
   output logic                              busy_o
);

   arb_state_e             state_q, state_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [NUM_REQUEST-1:0] grant_q, grant_d;
   logic [IW-1:0]          grant_idx_q, grant_idx_d;

   logic [NUM_REQUEST-1:0] pick_onehot;
   logic [IW-1:0]          pick_idx;
   logic                   sel_valid;
   logic                   sel_last;
   logic                   last_hs;

   rr_prio_pick #(
      .N  (NUM_REQUEST),
      .IW (IW)
   ) u_pick (
      .req    (s_valid_i),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      m_data_o  = '0;
      for (int unsigned k = 0; k < NUM_REQUEST; k++) begin
         if (grant_idx_q == IW'(k)) begin
            sel_valid = s_valid_i[k];
            sel_last  = s_last_i[k];
            m_data_o  = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      m_valid_o = 1'b0;
      m_last_o  = 1'b0;
      s_ready_o = '0;
      if (state_q == LOCKED) begin
         m_valid_o = sel_valid;
         m_last_o  = sel_last;
         s_ready_o = grant_q & {NUM_REQUEST{m_ready_i}};
      end
   end

   assign last_hs = m_valid_o & m_ready_i & m_last_o;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      grant_idx_d = grant_idx_q;
      unique case (state_q)
         IDLE: begin
            if (|s_valid_i) begin
               state_d     = LOCKED;
               grant_d     = pick_onehot;
               grant_idx_d = pick_idx;
            end
         end
         LOCKED: begin
            if (last_hs) begin
               state_d = IDLE;
               grant_d = '0;
               // Explicit wrap so non-power-of-two counts never point past the last input.
               ptr_d   = (grant_idx_q == IW'(NUM_REQUEST - 1)) ? '0 : grant_idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         grant_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
      end
   end

   assign grant_o     = grant_q;
   assign grant_idx_o = grant_idx_q;
   assign busy_o      = (state_q == LOCKED);

   a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(grant_o));
   a_grant_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ((grant_o != '0) == busy_o));
   a_ready_granted: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ((s_ready_o & ~grant_o) == '0));

endmodule

// File: tb/tb_stream_rr_arb.sv
// Directed bench for stream_rr_arb with four 32-bit inputs.
module tb_stream_rr_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 32;

   logic            clk_i;
   logic            rst_ni;
   logic [N-1:0]    s_valid_i;
   logic [N*DW-1:0] s_data_i;
   logic [N-1:0]    s_last_i;
   logic [N-1:0]    s_ready_o;
   logic            m_valid_o;
   logic [DW-1:0]   m_data_o;
   logic            m_last_o;
   logic            m_ready_i;
   logic [N-1:0]    grant_o;
   logic [1:0]      grant_idx_o;
   logic            busy_o;

   int checks = 0;
   int errors = 0;

   stream_rr_arb #(
      .NUM_REQUEST (N),
      .DATA_WIDTH  (DW)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .s_valid_i   (s_valid_i),
      .s_data_i    (s_data_i),
      .s_last_i    (s_last_i),
      .s_ready_o   (s_ready_o),
      .m_valid_o   (m_valid_o),
      .m_data_o    (m_data_o),
      .m_last_o    (m_last_o),
      .m_ready_i   (m_ready_i),
      .grant_o     (grant_o),
      .grant_idx_o (grant_idx_o),
      .busy_o      (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_data(input int k, input logic [DW-1:0] val);
      s_data_i[k*DW +: DW] = val;
   endtask

   logic [N-1:0]  rr_grant [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [DW-1:0] rr_data  [4] = '{32'h11, 32'h12, 32'h13, 32'h10};

   initial begin
      // Reset with every input requesting
      rst_ni    = 1'b0;
      m_ready_i = 1'b1;
      s_valid_i = 4'b1111;
      s_last_i  = 4'b1111;
      s_data_i  = '0;
      for (int k = 0; k < 4; k++) set_data(k, 32'h10 + k);
      #1;
      chk("rst_m_valid", m_valid_o, 1'b0);
      chk("rst_s_ready", s_ready_o, 4'b0000);
      chk("rst_grant", grant_o, 4'b0000);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_grant_idx", grant_idx_o, 2'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      #1;
      chk("post_rst_idle_grant", grant_o, 4'b0000);
      tick();
      #1;
      chk("first_grant", grant_o, 4'b0001);
      chk("first_busy", busy_o, 1'b1);
      chk("first_m_valid", m_valid_o, 1'b1);
      chk("first_m_data", m_data_o, 32'h10);
      chk("first_s_ready", s_ready_o, 4'b0001);

      // Round-robin with single-beat packets: IDLE bubble between grants
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         chk("rr_bubble_grant", grant_o, 4'b0000);
         chk("rr_bubble_m_valid", m_valid_o, 1'b0);
         tick();
         #1;
         chk("rr_grant", grant_o, rr_grant[i]);
         chk("rr_m_data", m_data_o, rr_data[i]);
      end

      // Packet lock: input 2 sends 3 beats while input 0 waits
      tick();
      s_valid_i = 4'b0100;
      s_last_i  = 4'b1011;
      set_data(2, 32'hA0);
      #1;
      chk("lock_idle_grant", grant_o, 4'b0000);
      tick();
      s_valid_i = 4'b0101;
      #1;
      chk("lock_grant_b0", grant_o, 4'b0100);
      chk("lock_idx_b0", grant_idx_o, 2'd2);
      chk("lock_data_b0", m_data_o, 32'hA0);
      chk("lock_last_b0", m_last_o, 1'b0);
      chk("lock_s_ready_b0", s_ready_o, 4'b0100);
      tick();
      set_data(2, 32'hA1);
      #1;
      chk("lock_grant_b1", grant_o, 4'b0100);
      chk("lock_data_b1", m_data_o, 32'hA1);
      tick();
      set_data(2, 32'hA2);
      s_last_i = 4'b1111;
      #1;
      chk("lock_grant_b2", grant_o, 4'b0100);
      chk("lock_data_b2", m_data_o, 32'hA2);
      chk("lock_last_b2", m_last_o, 1'b1);
      tick();
      s_valid_i = 4'b0001;
      #1;
      chk("lock_after_busy", busy_o, 1'b0);
      tick();
      #1;
      chk("lock_next_grant", grant_o, 4'b0001);
      chk("lock_next_data", m_data_o, 32'h10);

      // Backpressure on input 1's second beat
      tick();
      s_valid_i = 4'b0010;
      s_last_i  = 4'b1101;
      set_data(1, 32'hB0);
      tick();
      #1;
      chk("bp_grant", grant_o, 4'b0010);
      chk("bp_data_b0", m_data_o, 32'hB0);
      tick();
      set_data(1, 32'hB1);
      s_last_i  = 4'b1111;
      m_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_hold_grant", grant_o, 4'b0010);
         chk("bp_hold_data", m_data_o, 32'hB1);
         chk("bp_hold_s_ready", s_ready_o, 4'b0000);
         chk("bp_hold_m_valid", m_valid_o, 1'b1);
         tick();
      end
      m_ready_i = 1'b1;
      #1;
      chk("bp_release_s_ready", s_ready_o, 4'b0010);
      chk("bp_release_data", m_data_o, 32'hB1);
      tick();
      s_valid_i = 4'b1000;
      s_last_i  = 4'b0111;
      set_data(3, 32'hC0);
      #1;
      chk("bp_done_busy", busy_o, 1'b0);

      // Valid gap on input 3 while input 1 waits
      tick();
      #1;
      chk("gap_grant", grant_o, 4'b1000);
      chk("gap_data_c0", m_data_o, 32'hC0);
      s_valid_i = 4'b1010;
      tick();
      s_valid_i = 4'b0010;
      #1;
      chk("gap1_m_valid", m_valid_o, 1'b0);
      chk("gap1_grant", grant_o, 4'b1000);
      tick();
      #1;
      chk("gap2_m_valid", m_valid_o, 1'b0);
      chk("gap2_grant", grant_o, 4'b1000);
      chk("gap2_s_ready", s_ready_o, 4'b1000);
      tick();
      s_valid_i = 4'b1010;
      s_last_i  = 4'b1111;
      set_data(3, 32'hC1);
      #1;
      chk("gap_end_m_valid", m_valid_o, 1'b1);
      chk("gap_end_m_last", m_last_o, 1'b1);
      chk("gap_end_data", m_data_o, 32'hC1);
      tick();
      s_valid_i = 4'b0010;
      #1;
      chk("gap_idle_grant", grant_o, 4'b0000);
      tick();
      #1;
      chk("gap_next_grant", grant_o, 4'b0010);
      chk("gap_next_idx", grant_idx_o, 2'd1);

      // Async reset mid-packet, with ptr at 2 beforehand
      tick();
      s_valid_i = 4'b1000;
      s_last_i  = 4'b0111;
      tick();
      #1;
      chk("ar_pre_grant", grant_o, 4'b1000);
      s_valid_i = 4'b1111;
      s_last_i  = 4'b1111;
      #1;
      rst_ni = 1'b0;
      #1;
      chk("ar_m_valid", m_valid_o, 1'b0);
      chk("ar_s_ready", s_ready_o, 4'b0000);
      chk("ar_grant", grant_o, 4'b0000);
      chk("ar_busy", busy_o, 1'b0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      #1;
      chk("ar_idle_grant", grant_o, 4'b0000);
      tick();
      #1;
      chk("ar_restart_grant", grant_o, 4'b0001);
      chk("ar_restart_idx", grant_idx_o, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
